// File: rtl/fetch_bundle_unit.sv
// Fetch stage: issues one word PC per cycle and packs BUNDLE_WORDS words into a bundle queued toward decode.
// Latency: with hits every cycle the first bundle is visible BUNDLE_WORDS cycles after its first fetch.
// Backpressure: a full bundle FIFO stalls fetch on the last word; a redirect flushes the FIFO and the partial bundle.
module fetch_bundle_unit #(
    parameter int          BUNDLE_WORDS = 2,
    parameter int          FIFO_DEPTH   = 2,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [31:0]               imem_pc,
    input  logic                      imem_hit,
    input  logic [31:0]               imem_word,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    output logic                      bundle_valid,
    input  logic                      bundle_ready,
    output logic [32*BUNDLE_WORDS-1:0] bundle,
    output logic [31:0]               bundle_pc,
    output logic [15:0]               miss_count
);

    localparam int BW  = BUNDLE_WORDS;
    localparam int BWB = 32 * BW;
    localparam int ASB = 32 * (BW - 1);
    localparam int WW  = (BW > 1) ? $clog2(BW) : 1;
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    localparam logic [WW-1:0] WIDX_LAST = WW'(BW - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);

    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [WW-1:0]  widx_q, widx_d;
    logic [ASB-1:0] asm_q, asm_d;
    logic [31:0]    start_pc_q, start_pc_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [15:0]    miss_q, miss_d;
    logic [BWB-1:0] fifo_dat_q [FIFO_DEPTH];
    logic [BWB-1:0] fifo_dat_d [FIFO_DEPTH];
    logic [31:0]    fifo_pc_q  [FIFO_DEPTH];
    logic [31:0]    fifo_pc_d  [FIFO_DEPTH];

    logic full, last, pop, capture, push;

    always_comb begin
        full    = (count_q == DEPTH_C);
        last    = (widx_q == WIDX_LAST);
        pop     = (count_q != '0) && bundle_ready;
        // full is the registered count, so a pop this cycle does not free room for the last word
        capture = imem_hit && (!last || !full);
        push    = capture && last;

        fetch_pc_d = fetch_pc_q;
        widx_d     = widx_q;
        asm_d      = asm_q;
        start_pc_d = start_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        miss_d     = miss_q;
        fifo_dat_d = fifo_dat_q;
        fifo_pc_d  = fifo_pc_q;

        if (!imem_hit && miss_q != 16'hFFFF) begin
            miss_d = miss_q + 16'd1;
        end

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            widx_d     = '0;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (capture) begin
                fetch_pc_d = fetch_pc_q + 32'd1;
                for (int s = 0; s < BW - 1; s++) begin
                    if (widx_q == WW'(s)) begin
                        asm_d[s*32 +: 32] = imem_word;
                    end
                end
                if (widx_q == '0) begin
                    start_pc_d = fetch_pc_q;
                end
                widx_d = last ? '0 : widx_q + WW'(1);
            end
            if (push) begin
                fifo_dat_d[wr_ptr_q] = {imem_word, asm_q};
                fifo_pc_d[wr_ptr_q]  = start_pc_q;
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (!push && pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            widx_q     <= '0;
            asm_q      <= '0;
            start_pc_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            miss_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_dat_q[i] <= '0;
                fifo_pc_q[i]  <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            widx_q     <= widx_d;
            asm_q      <= asm_d;
            start_pc_q <= start_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            miss_q     <= miss_d;
            fifo_dat_q <= fifo_dat_d;
            fifo_pc_q  <= fifo_pc_d;
        end
    end

    assign imem_pc      = fetch_pc_q;
    assign bundle_valid = (count_q != '0);
    assign bundle       = fifo_dat_q[rd_ptr_q];
    assign bundle_pc    = fifo_pc_q[rd_ptr_q];
    assign miss_count   = miss_q;

endmodule

// File: tb/tb_fetch_bundle_unit.sv
// Directed vector bench for fetch_bundle_unit; memory returns 0xA0 + pc for every fetched word.
module tb_fetch_bundle_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_pc;
    logic        imem_hit;
    logic [31:0] imem_word;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        bundle_valid;
    logic        bundle_ready;
    logic [63:0] bundle;
    logic [31:0] bundle_pc;
    logic [15:0] miss_count;

    always #5 clk = ~clk;

    assign imem_word = 32'hA0 + imem_pc;

    fetch_bundle_unit #(
        .BUNDLE_WORDS(2),
        .FIFO_DEPTH  (2),
        .RESET_PC    (32'h0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_pc       (imem_pc),
        .imem_hit      (imem_hit),
        .imem_word     (imem_word),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .bundle_valid  (bundle_valid),
        .bundle_ready  (bundle_ready),
        .bundle        (bundle),
        .bundle_pc     (bundle_pc),
        .miss_count    (miss_count)
    );

    typedef struct {
        bit          rst;
        bit          hit;
        bit          rdy;
        bit          rv;
        logic [31:0] rpc;
        logic [31:0] epc;
        bit          evld;
        logic [63:0] ebun;
        logic [31:0] ebpc;
        logic [15:0] emiss;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add(bit rst, bit hit, bit rdy, bit rv, logic [31:0] rpc,
                                logic [31:0] epc, bit evld, logic [63:0] ebun,
                                logic [31:0] ebpc, logic [15:0] emiss);
        vec_t v;
        v.rst = rst; v.hit = hit; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.epc = epc; v.evld = evld; v.ebun = ebun; v.ebpc = ebpc; v.emiss = emiss;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // Called at a negedge: reset must clear outputs with no clock edge in between.
    task automatic reset_pulse(input int row);
        reset = 1'b0;
        #1;
        chk("rst_imem_pc", row, 64'(imem_pc), 64'h0);
        chk("rst_valid", row, 64'(bundle_valid), 64'h0);
        chk("rst_bundle", row, bundle, 64'h0);
        chk("rst_bundle_pc", row, 64'(bundle_pc), 64'h0);
        chk("rst_miss", row, 64'(miss_count), 64'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset          = 1'b1;
        imem_hit       = 1'b0;
        bundle_ready   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Streaming with decode always ready
        add(1,1,1,0,0, 32'h0,0,64'h0,32'h0,0);
        add(0,1,1,0,0, 32'h1,0,64'h0,32'h0,0);
        add(0,1,1,0,0, 32'h2,1,{32'hA1,32'hA0},32'h0,0);
        add(0,1,1,0,0, 32'h3,0,64'h0,32'h0,0);
        add(0,1,1,0,0, 32'h4,1,{32'hA3,32'hA2},32'h2,0);
        add(0,1,1,0,0, 32'h5,0,64'h0,32'h0,0);
        add(0,1,1,0,0, 32'h6,1,{32'hA5,32'hA4},32'h4,0);
        // Decode stalled: FIFO fills, fetch blocks at pc 5, one pop does not unblock that cycle
        add(1,1,0,0,0, 32'h0,0,64'h0,32'h0,0);
        add(0,1,0,0,0, 32'h1,0,64'h0,32'h0,0);
        add(0,1,0,0,0, 32'h2,1,{32'hA1,32'hA0},32'h0,0);
        add(0,1,0,0,0, 32'h3,1,{32'hA1,32'hA0},32'h0,0);
        add(0,1,0,0,0, 32'h4,1,{32'hA1,32'hA0},32'h0,0);
        add(0,1,1,0,0, 32'h5,1,{32'hA1,32'hA0},32'h0,0);
        add(0,1,0,0,0, 32'h5,1,{32'hA3,32'hA2},32'h2,0);
        add(0,1,1,0,0, 32'h6,1,{32'hA3,32'hA2},32'h2,0);
        add(0,1,1,0,0, 32'h7,1,{32'hA5,32'hA4},32'h4,0);
        add(0,1,1,0,0, 32'h8,1,{32'hA7,32'hA6},32'h6,0);
        add(0,1,1,0,0, 32'h9,0,64'h0,32'h0,0);
        // Three misses at pc 1
        add(1,1,1,0,0, 32'h0,0,64'h0,32'h0,0);
        add(0,0,1,0,0, 32'h1,0,64'h0,32'h0,0);
        add(0,0,1,0,0, 32'h1,0,64'h0,32'h0,1);
        add(0,0,1,0,0, 32'h1,0,64'h0,32'h0,2);
        add(0,1,1,0,0, 32'h1,0,64'h0,32'h0,3);
        add(0,1,1,0,0, 32'h2,1,{32'hA1,32'hA0},32'h0,3);
        // Redirect with a queued bundle and a partial one, plus a miss and a pop request that cycle
        add(1,1,0,0,0, 32'h0,0,64'h0,32'h0,0);
        add(0,1,0,0,0, 32'h1,0,64'h0,32'h0,0);
        add(0,1,0,0,0, 32'h2,1,{32'hA1,32'hA0},32'h0,0);
        add(0,0,1,1,32'h100, 32'h3,1,{32'hA1,32'hA0},32'h0,0);
        add(0,1,1,0,0, 32'h100,0,64'h0,32'h0,1);
        add(0,1,1,0,0, 32'h101,0,64'h0,32'h0,1);
        add(0,1,1,0,0, 32'h102,1,{32'h1A1,32'h1A0},32'h100,1);
        // Async reset mid-bundle, then restart from the reset PC
        add(1,1,0,0,0, 32'h0,0,64'h0,32'h0,0);
        add(0,1,0,0,0, 32'h1,0,64'h0,32'h0,0);
        add(0,0,0,0,0, 32'h2,1,{32'hA1,32'hA0},32'h0,0);
        add(0,1,0,0,0, 32'h2,1,{32'hA1,32'hA0},32'h0,1);
        add(1,1,1,0,0, 32'h0,0,64'h0,32'h0,0);
        add(0,1,1,0,0, 32'h1,0,64'h0,32'h0,0);
        add(0,1,1,0,0, 32'h2,1,{32'hA1,32'hA0},32'h0,0);
        // Redirect to the last word address: bundle spans the PC wrap
        add(1,1,1,1,32'hFFFF_FFFF, 32'h0,0,64'h0,32'h0,0);
        add(0,1,1,0,0, 32'hFFFF_FFFF,0,64'h0,32'h0,0);
        add(0,1,1,0,0, 32'h0,0,64'h0,32'h0,0);
        add(0,1,1,0,0, 32'h1,1,{32'hA0,32'h9F},32'hFFFF_FFFF,0);
        add(0,1,1,0,0, 32'h2,0,64'h0,32'h0,0);
        add(0,1,1,0,0, 32'h3,1,{32'hA2,32'hA1},32'h1,0);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) begin
                reset_pulse(i);
            end
            chk("imem_pc", i, 64'(imem_pc), 64'(vecs[i].epc));
            chk("bundle_valid", i, 64'(bundle_valid), 64'(vecs[i].evld));
            chk("miss_count", i, 64'(miss_count), 64'(vecs[i].emiss));
            if (vecs[i].evld) begin
                chk("bundle", i, bundle, vecs[i].ebun);
                chk("bundle_pc", i, 64'(bundle_pc), 64'(vecs[i].ebpc));
            end
            imem_hit       = vecs[i].hit;
            bundle_ready   = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
